dcalc_vector_length_n: RTL and testbench

- Parametrised, fixed-point successor to the three-channel vector-length block.
- Accepts two N-channel signed vectors and a mode bit.
- Computes either the raw dot product sum(a_i*b_i) or the length floor(sqrt(sum(a_i*b_i))).
- Uses one time-shared multiplier-accumulator and a one-bit-per-cycle integer square root, behind valid/ready handshakes on input and output. Sits in the collision-detection datapath ahead of the radius compare.

---
 rtl/dcalc_vector_length_n.sv | 138 +++++++++++++
 tb/tb_dcalc_vector_length_n.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcalc_vector_length_n.sv
// N-channel signed dot product with an optional floor square root.
// One shared MAC (one element per cycle) feeds a one-bit-per-cycle restoring root.
module dcalc_vector_length_n #(
  parameter  int W  = 16,
  parameter  int N  = 3,
  localparam int DW = 2*W + $clog2(N)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            mode,
  input  logic [N*W-1:0]  a_vec,
  input  logic [N*W-1:0]  b_vec,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   res,
  output logic            neg,
  output logic            busy
);

  localparam int RW = (DW + 1) / 2;
  localparam int RD = 2 * RW;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(RW + 1);

  typedef enum logic [1:0] {IDLE, MAC, SQRT, DONE} state_t;

  state_t state, state_nx;

  logic [N*W-1:0]         a_q, b_q;
  logic                   mode_q;
  logic signed [DW-1:0]   acc, acc_nx, ax, bx, prod;
  logic signed [W-1:0]    ea, eb;
  logic [IW-1:0]          idx;
  logic [RD-1:0]          rad;
  logic [RW+1:0]          rem, rem_sh, trial;
  logic [RW-1:0]          root, root_nx;
  logic [CW-1:0]          scnt;
  logic                   rem_ge, mac_last, sqrt_last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == MAC) || (state == SQRT);

  always_comb begin
    ea = '0;
    eb = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx == IW'(i)) begin
        ea = a_q[i*W +: W];
        eb = b_q[i*W +: W];
      end
    end
    // Widen before multiplying so the product is formed at full accumulator width.
    ax        = DW'(ea);
    bx        = DW'(eb);
    prod      = ax * bx;
    acc_nx    = acc + prod;
    mac_last  = (idx == IW'(N - 1));
    sqrt_last = (scnt == CW'(RW - 1));
    // Restoring root step: bring down the next two radicand bits, try (4*root + 1).
    rem_sh    = (rem << 2) | (RW+2)'(rad[RD-1 -: 2]);
    trial     = {root, 2'b01};
    rem_ge    = (rem_sh >= trial);
    root_nx   = rem_ge ? ((root << 1) | RW'(1)) : (root << 1);
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_valid) state_nx = MAC;
      MAC:  if (mac_last) state_nx = (mode_q || acc_nx <= 0) ? DONE : SQRT;
      SQRT: if (sqrt_last) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= 1'b0;
      acc    <= '0;
      idx    <= '0;
      rad    <= '0;
      rem    <= '0;
      root   <= '0;
      scnt   <= '0;
      res    <= '0;
      neg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q    <= a_vec;
            b_q    <= b_vec;
            mode_q <= mode;
            acc    <= '0;
            idx    <= '0;
          end
        end
        MAC: begin
          acc <= acc_nx;
          idx <= idx + IW'(1);
          if (mac_last) begin
            neg <= (acc_nx < 0);
            if (mode_q) begin
              res <= acc_nx;
            end else if (acc_nx <= 0) begin
              res <= '0;
            end else begin
              rad  <= RD'($unsigned(acc_nx));
              rem  <= '0;
              root <= '0;
              scnt <= '0;
            end
          end
        end
        SQRT: begin
          rem  <= rem_ge ? (rem_sh - trial) : rem_sh;
          root <= root_nx;
          rad  <= rad << 2;
          scnt <= scnt + CW'(1);
          if (sqrt_last) res <= DW'(root_nx);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcalc_vector_length_n.sv
// Scoreboard bench for dcalc_vector_length_n: directed cases, mid-operation
// resets, backpressure and randomized operations against an arithmetic model.
module tb_dcalc_vector_length_n;

  localparam int W  = 16;
  localparam int N  = 3;
  localparam int DW = 2*W + $clog2(N);
  localparam int RW = (DW + 1) / 2;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic           mode = 1'b0;
  logic [N*W-1:0] a_vec = '0;
  logic [N*W-1:0] b_vec = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [DW-1:0]  res;
  logic           neg;
  logic           busy;

  always #5 CLK = ~CLK;

  dcalc_vector_length_n #(.W(W), .N(N)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .a_vec(a_vec), .b_vec(b_vec), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .neg(neg), .busy(busy)
  );

  typedef struct {
    logic [DW-1:0] res;
    logic          neg;
    int            lat;
    int            start;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   hold_next = -1;
  bit   mon_active = 1'b0;
  bit   expect_idle = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic longint isqrt(input longint s);
    longint r;
    r = longint'($floor($sqrt(real'(s))));
    while (r * r > s) r--;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  function automatic exp_t model(input int a[N], input int b[N], input bit m, input int start);
    exp_t   e;
    longint s = 0;
    longint r;
    for (int i = 0; i < N; i++) s += longint'(a[i]) * longint'(b[i]);
    e.start = start;
    e.neg   = (s < 0);
    if (m) begin
      e.res = s[DW-1:0];
      e.lat = N + 1;
    end else if (s <= 0) begin
      e.res = '0;
      e.lat = N + 1;
    end else begin
      r     = isqrt(s);
      e.res = r[DW-1:0];
      e.lat = N + RW + 1;
    end
    return e;
  endfunction

  // Waits for in_ready (pulsing junk on the inputs meanwhile), then presents one operation.
  task automatic issue(input int a[N], input int b[N], input bit m, input bit push);
    int t = 0;
    @(negedge CLK);
    while (in_ready !== 1'b1) begin
      in_valid = 1'($urandom % 2);
      a_vec    = {$urandom, $urandom};
      b_vec    = {$urandom, $urandom};
      mode     = 1'($urandom % 2);
      t++;
      if (t > 300) begin
        n_err++;
        $display("FAIL in_ready_timeout: got in_ready=%b, expected 1 within 300 cycles", in_ready);
        in_valid = 1'b0;
        return;
      end
      @(negedge CLK);
    end
    for (int i = 0; i < N; i++) begin
      a_vec[i*W +: W] = a[i][W-1:0];
      b_vec[i*W +: W] = b[i][W-1:0];
    end
    mode     = m;
    in_valid = 1'b1;
    if (push) begin
      sb.push_back(model(a, b, m, cyc));
      n_vec++;
    end
    @(negedge CLK);
    in_valid = 1'b0;
    a_vec    = {$urandom, $urandom};
    b_vec    = {$urandom, $urandom};
    mode     = ~mode;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_res"}, res, 0);
    check({tag, "_neg"}, neg, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    n_vec++;
  endtask

  // Starts a length operation, aborts it with a 2-cycle reset after 'wait_cycles'.
  task automatic reset_mid(input int wait_cycles, input string tag);
    issue('{3, 4, 0}, '{3, 4, 0}, 1'b0, 1'b0);
    repeat (wait_cycles) @(negedge CLK);
    check({tag, "_busy_before"}, busy, 1);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check_reset_state(tag);
    repeat (30) @(negedge CLK);
    check({tag, "_no_stale"}, out_valid, 0);
    check({tag, "_idle_after"}, in_ready, 1);
  endtask

  // Monitor: pops the expectation on the first valid cycle, applies backpressure.
  initial begin
    exp_t cur;
    int   hold = 0;
    forever begin
      @(negedge CLK);
      if (RST === 1'b1) begin
        mon_active  = 1'b0;
        expect_idle = 1'b0;
        out_ready   = 1'b0;
      end else if (out_valid === 1'b1) begin
        if (!mon_active) begin
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output: got res=%0h neg=%b, expected no output", res, neg);
            out_ready = 1'b1;
          end else begin
            cur        = sb.pop_front();
            mon_active = 1'b1;
            check("latency", 64'(cyc - cur.start), 64'(cur.lat));
            hold      = (hold_next >= 0) ? hold_next : int'($urandom_range(0, 3));
            hold_next = -1;
          end
        end
        if (mon_active) begin
          check("res", res, cur.res);
          check("neg", neg, cur.neg);
          check("in_ready_while_done", in_ready, 0);
          check("busy_while_done", busy, 0);
          if (hold > 0) begin
            hold--;
            out_ready = 1'b0;
          end else begin
            out_ready   = 1'b1;
            mon_active  = 1'b0;
            expect_idle = 1'b1;
          end
        end
      end else begin
        if (expect_idle) begin
          check("idle_after_accept", in_ready, 1);
          expect_idle = 1'b0;
        end
        if (mon_active) begin
          n_err++;
          $display("FAIL valid_dropped: got out_valid=0, expected 1 until accepted");
          mon_active = 1'b0;
        end
        out_ready = 1'b0;
      end
    end
  end

  initial begin
    int a[N];
    int b[N];
    int t;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check_reset_state("reset");

    issue('{3, 4, 0}, '{3, 4, 0}, 1'b0, 1'b1);
    issue('{1, -2, 3}, '{4, 5, -6}, 1'b1, 1'b1);
    issue('{-3, 0, 0}, '{3, 0, 0}, 1'b0, 1'b1);
    issue('{0, 0, 0}, '{0, 0, 0}, 1'b0, 1'b1);
    issue('{-32768, -32768, -32768}, '{-32768, -32768, -32768}, 1'b0, 1'b1);
    issue('{-32768, -32768, -32768}, '{-32768, -32768, -32768}, 1'b1, 1'b1);
    hold_next = 10;
    issue('{100, -7, 250}, '{90, 3, 11}, 1'b0, 1'b1);
    issue('{5, 6, 7}, '{-1, -2, -3}, 1'b1, 1'b1);

    reset_mid(1, "rst_mac");
    issue('{12, 0, 5}, '{12, 0, 5}, 1'b0, 1'b1);
    reset_mid(8, "rst_sqrt");
    issue('{32767, -32768, 1}, '{32767, -32768, 1}, 1'b0, 1'b1);

    for (int k = 0; k < 80; k++) begin
      for (int i = 0; i < N; i++) begin
        a[i] = ($urandom % 2) ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 40)) - 20;
        b[i] = ($urandom % 3 == 0) ? a[i]
             : (($urandom % 2) ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 40)) - 20);
      end
      issue(a, b, 1'($urandom % 2), 1'b1);
    end

    t = 0;
    while ((sb.size() != 0 || mon_active || in_ready !== 1'b1) && t < 1000) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 1000) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
    end
    repeat (3) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
